// File: rtl/bm_arbiter_sequencer.sv
// Shares one external 8-bit BitManipulation unit between two requesters.
// Each accepted request is iterated one bit per cycle through the BM unit.
// The optional macro BMSEQ_FIXED_PRIO_EN makes req0 always win over req1.
`timescale 1ns/1ps
module bm_arbiter_sequencer #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_op,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_op,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              busy,
    output logic [DATA_W-1:0] bm_data_in,
    output logic              bm_enable_shift,
    output logic              bm_direction_shift,
    output logic              bm_enable_rotate,
    output logic              bm_direction_rotate,
    input  logic [DATA_W-1:0] bm_data_out,
    input  logic              bm_carry
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] work_q;
    logic [1:0]        op_q;
    logic [AMT_W-1:0]  cnt_q;
    logic              id_q;

    logic              gnt0, gnt1, accept;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_op;
    logic [AMT_W-1:0]  sel_amt;

`ifndef BMSEQ_FIXED_PRIO_EN
    // Index of the requester granted most recently; reset value lets req0 win the first tie.
    logic last_gnt;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
`ifdef BMSEQ_FIXED_PRIO_EN
            gnt0 = req0_valid;
            gnt1 = req1_valid & ~req0_valid;
`else
            if (req0_valid && req1_valid) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
`endif
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign sel_data   = gnt1 ? req1_data : req0_data;
    assign sel_op     = gnt1 ? req1_op   : req0_op;
    assign sel_amt    = gnt1 ? req1_amt  : req0_amt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (sel_amt == '0) ? RESP : RUN;
            RUN:  if (cnt_q == AMT_W'(1)) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bm_enable_shift     = 1'b0;
        bm_direction_shift  = 1'b0;
        bm_enable_rotate    = 1'b0;
        bm_direction_rotate = 1'b0;
        if (state == RUN) begin
            case (op_q)
                OP_SHL: bm_enable_shift = 1'b1;
                OP_SHR: begin
                    bm_enable_shift    = 1'b1;
                    bm_direction_shift = 1'b1;
                end
                OP_ROL: bm_enable_rotate = 1'b1;
                OP_ROR: begin
                    bm_enable_rotate    = 1'b1;
                    bm_direction_rotate = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bm_data_in = work_q;
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);

    // Response registers load only on the edge entering RESP so they hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work_q    <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
`ifndef BMSEQ_FIXED_PRIO_EN
            last_gnt  <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                work_q <= sel_data;
                op_q   <= sel_op;
                cnt_q  <= sel_amt;
                id_q   <= gnt1;
`ifndef BMSEQ_FIXED_PRIO_EN
                last_gnt <= gnt1;
`endif
                if (sel_amt == '0) begin
                    rsp_id    <= gnt1;
                    rsp_data  <= sel_data;
                    rsp_carry <= 1'b0;
                end
            end
            if (state == RUN) begin
                work_q <= bm_data_out;
                cnt_q  <= cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    rsp_id    <= id_q;
                    rsp_data  <= bm_data_out;
                    rsp_carry <= bm_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_bm_arbiter_sequencer.sv
// Directed bench for bm_arbiter_sequencer with a behavioural BM unit attached.
`timescale 1ns/1ps
module tb_bm_arbiter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [1:0] req0_op, req1_op;
    logic [2:0] req0_amt, req1_amt;
    logic       rsp_valid, rsp_id, rsp_carry, busy;
    logic [7:0] rsp_data, bm_data_in, bm_data_out;
    logic       bm_enable_shift, bm_direction_shift, bm_enable_rotate, bm_direction_rotate;
    logic       bm_carry;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bm_arbiter_sequencer #(.DATA_W(8), .AMT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_op(req0_op), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_op(req1_op), .req1_amt(req1_amt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .busy(busy), .bm_data_in(bm_data_in),
        .bm_enable_shift(bm_enable_shift), .bm_direction_shift(bm_direction_shift),
        .bm_enable_rotate(bm_enable_rotate), .bm_direction_rotate(bm_direction_rotate),
        .bm_data_out(bm_data_out), .bm_carry(bm_carry)
    );

    // Behavioural 1-bit BitManipulation unit
    always_comb begin
        bm_data_out = bm_data_in;
        bm_carry    = 1'b0;
        if (bm_enable_shift) begin
            if (bm_direction_shift) begin
                bm_data_out = {1'b0, bm_data_in[7:1]};
                bm_carry    = bm_data_in[0];
            end else begin
                bm_data_out = {bm_data_in[6:0], 1'b0};
                bm_carry    = bm_data_in[7];
            end
        end else if (bm_enable_rotate) begin
            if (bm_direction_rotate) begin
                bm_data_out = {bm_data_in[0], bm_data_in[7:1]};
                bm_carry    = bm_data_in[0];
            end else begin
                bm_data_out = {bm_data_in[6:0], bm_data_in[7]};
                bm_carry    = bm_data_in[7];
            end
        end
    end

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic [1:0] op;
        logic [2:0] amt;
        logic [7:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] ctrl_for(input logic [1:0] op);
        case (op)
            2'b00:   return 4'b1000;
            2'b01:   return 4'b1100;
            2'b10:   return 4'b0010;
            default: return 4'b0011;
        endcase
    endfunction

    function automatic logic [3:0] ctrl_now();
        return {bm_enable_shift, bm_direction_shift, bm_enable_rotate, bm_direction_rotate};
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = '0; req0_op = '0; req0_amt = '0;
        req1_valid = 1'b0; req1_data = '0; req1_op = '0; req1_amt = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_req(input int idx, input vec_t v);
        int  n = 0;
        int  ctrl_err = 0;
        int  en_cyc = 0;
        bit  got = 0;
        @(negedge clk);
        if (v.id) begin
            req1_valid = 1'b1; req1_data = v.data; req1_op = v.op; req1_amt = v.amt;
        end else begin
            req0_valid = 1'b1; req0_data = v.data; req0_op = v.op; req0_amt = v.amt;
        end
        #1;
        check($sformatf("v%0d ready", idx), 32'(v.id ? req1_ready : req0_ready), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (ctrl_now() != 4'b0000) en_cyc++;
            if (rsp_valid) begin
                got = 1;
                if (ctrl_now() != 4'b0000 || !busy) ctrl_err++;
            end else if (ctrl_now() != ctrl_for(v.op) || !busy || bm_data_in === 8'hxx) begin
                ctrl_err++;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(n), 32'(v.amt) + 32'd1);
        check($sformatf("v%0d id", idx), 32'(rsp_id), 32'(v.id));
        check($sformatf("v%0d data", idx), 32'(rsp_data), 32'(v.exp_data));
        check($sformatf("v%0d carry", idx), 32'(rsp_carry), 32'(v.exp_carry));
        check($sformatf("v%0d ctrl_errs", idx), 32'(ctrl_err), 32'd0);
        check($sformatf("v%0d enable_cycles", idx), 32'(en_cyc), 32'(v.amt));
        @(negedge clk);
        check($sformatf("v%0d after_rsp", idx), {29'd0, rsp_valid, busy, 1'b0}, 32'd0);
        check($sformatf("v%0d hold_data", idx), 32'(rsp_data), 32'(v.exp_data));
    endtask

    initial begin
        logic exp_ids[4];
        logic ids[4];
        int   got;
        int   k;
        int   bad;

        vecs[0] = '{1'b0, 8'h81, 2'b00, 3'd1, 8'h02, 1'b1};
        vecs[1] = '{1'b1, 8'h96, 2'b11, 3'd3, 8'hD2, 1'b1};
        vecs[2] = '{1'b0, 8'h5A, 2'b10, 3'd0, 8'h5A, 1'b0};
        vecs[3] = '{1'b0, 8'h01, 2'b01, 3'd2, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'hF0, 2'b10, 3'd4, 8'h0F, 1'b1};
        vecs[5] = '{1'b1, 8'hA5, 2'b11, 3'd0, 8'hA5, 1'b0};
        vecs[6] = '{1'b0, 8'hFF, 2'b00, 3'd7, 8'h80, 1'b1};
        vecs[7] = '{1'b1, 8'h80, 2'b01, 3'd7, 8'h01, 1'b0};
        vecs[8] = '{1'b0, 8'h01, 2'b11, 3'd1, 8'h80, 1'b1};
        vecs[9] = '{1'b1, 8'h3C, 2'b00, 3'd2, 8'hF0, 1'b0};

        rst = 1'b1;
        idle_inputs();
        do_reset();

        check("reset_rsp", {28'd0, rsp_valid, rsp_id, rsp_carry, busy}, 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_bm", {20'd0, bm_data_in, ctrl_now()}, 32'd0);

        for (int i = 0; i < 10; i++) run_req(i, vecs[i]);

        // Both requesters held valid from reset, amt 1 each
        do_reset();
`ifdef BMSEQ_FIXED_PRIO_EN
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        req0_valid = 1'b1; req0_data = 8'h01; req0_op = 2'b00; req0_amt = 3'd1;
        req1_valid = 1'b1; req1_data = 8'h02; req1_op = 2'b00; req1_amt = 3'd1;
        got = 0;
        k = 0;
        bad = 0;
        while (got < 4 && k < 40) begin
            @(negedge clk);
            k++;
            if (rsp_valid) begin
                ids[got] = rsp_id;
                if (rsp_data != (rsp_id ? 8'h04 : 8'h02)) bad++;
                got++;
            end
        end
        idle_inputs();
        check("arb_rsp_count", 32'(got), 32'd4);
        check("arb_rsp_data_errs", 32'(bad), 32'd0);
        for (int i = 0; i < got; i++)
            check($sformatf("arb_grant%0d", i), 32'(ids[i]), 32'(exp_ids[i]));

        // Reset in the middle of a long request while req1 waits
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hF0; req0_op = 2'b10; req0_amt = 3'd7;
        req1_valid = 1'b1; req1_data = 8'h11; req1_op = 2'b00; req1_amt = 3'd1;
        #1;
        check("mid_rst_ready0", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || !busy) bad++;
        end
        check("mid_rst_running", 32'(bad), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_idle", {28'd0, rsp_valid, busy, req0_ready, req1_ready}, 32'd1);
        check("mid_rst_values", {19'd0, rsp_data, rsp_carry, ctrl_now()}, 32'd0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("mid_rst_req1_latency", 32'(k), 32'd2);
        check("mid_rst_req1_rsp", {23'd0, rsp_id, rsp_data}, {23'd0, 1'b1, 8'h22});
        check("mid_rst_req1_carry", 32'(rsp_carry), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bm_arbiter_sequencer.md
Name: bm_arbiter_sequencer

Overview:
Controller that shares one 8-bit BitManipulation unit (1-bit shift/rotate per pass) between two requesters, e.g. two cores of the multiprocessor ALU.
Accepts a multi-bit shift/rotate request (0–7 positions), arbitrates between requesters, and iterates the external BM instance once per cycle.
Returns the final data and the last carry-out on a one-cycle response strobe.
Sits between the core-side ALU request logic and a single external BitManipulation instance.

Parameters:
DATA_W, 8, datapath width; must equal the BM width (only 8 supported)
AMT_W, 3, width of shift amount; max amount 2^AMT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_data  input  DATA_W  operand
req0_op  input  2  00 shl, 01 shr, 10 rol, 11 ror
req0_amt  input  AMT_W  number of 1-bit steps
req1_valid / req1_ready / req1_data / req1_op / req1_amt  same as requester 0
rsp_valid  output  1  one-cycle result strobe
rsp_id  output  1  requester index of result
rsp_data  output  DATA_W  result
rsp_carry  output  1  carry of final step; 0 if amt=0
busy  output  1  high in RUN and RESP
bm_data_in  output  DATA_W  to BM data_in
bm_enable_shift, bm_direction_shift, bm_enable_rotate, bm_direction_rotate  output  1 each  to BM controls
bm_data_out  input  DATA_W  from BM data_out
bm_carry  input  1  from BM carry

Behaviour:
- Single clock clk; rst synchronous active-high. All state updates on the rising edge of clk.
- FSM states: IDLE, RUN, RESP.
- Reset: state IDLE; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, busy=0; all bm_enable_*=0; bm_data_in=0; RR pointer favours req0.
- IDLE arbitration (combinational):
  - readyN=1 only in IDLE, and only for the winner.
  - Single valid: that requester wins.
  - Both valid: the requester not granted last wins (round-robin).
  - Accept = validN & readyN. On accept, latch data, op, amt and id into internal registers and update the last-grant pointer.
- Inputs are sampled only on accept; changes while not ready are ignored. No queuing.
- Accept, amt=0: go to RESP; result = latched data, carry=0; BM never enabled.
- Accept, amt>0: go to RUN with count=amt.
- RUN, each cycle:
  - bm_data_in = working reg.
  - Drive the enable/direction for op:
    - shl: enable_shift=1, direction_shift=0
    - shr: enable_shift=1, direction_shift=1
    - rol: enable_rotate=1, direction_rotate=0
    - ror: enable_rotate=1, direction_rotate=1
  - At the edge: working reg <= bm_data_out, carry reg <= bm_carry, count <= count-1.
  - count==1 at the edge → RESP.
- Outside RUN: all bm_enable_* and bm_direction_* = 0; bm_data_in = working reg.
- RESP: rsp_valid=1 for exactly one cycle with rsp_id/rsp_data/rsp_carry; then IDLE. No response backpressure.
- rsp_data/rsp_id/rsp_carry hold their last values after rsp_valid drops.
- Latency: accept in cycle T → RUN T+1..T+amt → rsp_valid at T+amt+1; amt=0 gives rsp_valid at T+1.
- New accept is possible in the cycle after RESP at the earliest, so throughput is one request per amt+2 cycles.
- rst mid-operation (RUN or RESP): in-flight request dropped, no rsp_valid, return to reset values next cycle.

Optional Feature:
BMSEQ_FIXED_PRIO_EN
- Defined: fixed priority, req0 always wins when both are valid; last-grant pointer removed.
- Undefined (default): round-robin as above.

Test Plan:
1. req0 0x81 shl amt 1 at T → enable_shift=1, direction_shift=0 in T+1 only; rsp_valid at T+2: id 0, data 0x02, carry 1.
2. req1 0x96 ror amt 3 → intermediate 0x4B/c0, 0xA5/c1, 0xD2/c1; busy high T+1..T+4; rsp at T+4: id 1, data 0xD2, carry 1.
3. req0 0x5A rol amt 0 → no BM enable; rsp at T+1: data 0x5A, carry 0.
4. req0 0x01 shr amt 2 → steps 0x00/c1 then 0x00/c0; rsp: data 0x00, carry 0 (last step's carry).
5. Both valid held continuously after reset, amt 1 → grants 0,1,0,1; with BMSEQ_FIXED_PRIO_EN → 0,0,0,0.
6. rst pulsed during RUN of req0 0xF0 rol amt 7 → no rsp_valid for it; next cycle busy=0, IDLE; pending req1 accepted following cycle.
